// File: rtl/ethstream_framer.sv
// ethstream_framer: store-and-forward framer emitting a 16-bit LSB-first length prefix followed by the buffered packet.
module ethstream_framer #(
  parameter int ADDR_BITS = 11
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  input  logic       s_axis_tlast,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic       overflow,
  output logic       busy
);
  localparam int DEPTH = 2**ADDR_BITS;
  localparam logic [ADDR_BITS:0] one = 1;
  typedef enum logic [1:0] {FILL, LEN_LSB, LEN_MSB, DRAIN} state_t;
  state_t state, state_n;
  logic [7:0] mem [DEPTH];
  logic [7:0] rd_data;
  logic [ADDR_BITS:0] len, rd_ptr, rd_ptr_n;
  logic [15:0] len16;
  logic ovf_seen, s_fire, m_fire, full, last_beat;
  assign len16 = 16'(len);
  assign full = len[ADDR_BITS];
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;
  assign last_beat = (rd_ptr + one) == len;
  // rd_ptr_n is re-read every cycle so rd_data always holds mem[rd_ptr]: no bubble entering DRAIN
  always_comb begin
    s_axis_tready = resetn && state == FILL;
    m_axis_tvalid = resetn && state != FILL;
    busy = resetn && state != FILL;
    m_axis_tdata = state == LEN_LSB ? len16[7:0] : state == LEN_MSB ? len16[15:8] : rd_data;
    m_axis_tlast = m_axis_tvalid && state == DRAIN && last_beat;
    overflow = s_fire && full && !ovf_seen;
    state_n = state == FILL ? (s_fire && s_axis_tlast ? LEN_LSB : FILL)
            : !m_fire ? state
            : state == LEN_LSB ? LEN_MSB
            : state == LEN_MSB ? DRAIN
            : last_beat ? FILL : DRAIN;
    rd_ptr_n = state != DRAIN ? '0 : m_fire ? rd_ptr + one : rd_ptr;
  end
  always_ff @(posedge clk) begin
    rd_data <= mem[rd_ptr_n[ADDR_BITS-1:0]];
    if (s_fire && !full) mem[len[ADDR_BITS-1:0]] <= s_axis_tdata;
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= FILL;
      len <= '0;
      rd_ptr <= '0;
      ovf_seen <= 1'b0;
    end else begin
      state <= state_n;
      rd_ptr <= rd_ptr_n;
      len <= (state == DRAIN && m_fire && last_beat) ? '0 : (s_fire && !full) ? len + one : len;
      ovf_seen <= s_fire ? (!s_axis_tlast && (ovf_seen || full)) : ovf_seen;
    end
  end
endmodule

// File: tb/tb_ethstream_framer.sv
// tb_ethstream_framer: randomized checks of ethstream_framer against a queue-based frame model (depths 2048 and 16).
module tb_ethstream_framer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [7:0] s_tdata [2];
  logic       s_tvalid [2];
  logic       s_tready [2];
  logic       s_tlast [2];
  logic [7:0] m_tdata [2];
  logic       m_tvalid [2];
  logic       m_tready [2];
  logic       m_tlast [2];
  logic       ovf [2];
  logic       busy [2];
  int checks = 0;
  int errors = 0;
  logic [7:0] pkt [$];
  logic       tl [$];
  logic [7:0] got_d [$];
  logic       got_l [$];
  logic [7:0] exp_d [$];
  logic       exp_l [$];
  int ovf_n, ovf_at, stall_err, hold_err, span, gaps;
  bit timed_out;

  always #5 clk = ~clk;

  ethstream_framer dut0 (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_tdata[0]), .s_axis_tvalid(s_tvalid[0]), .s_axis_tready(s_tready[0]), .s_axis_tlast(s_tlast[0]),
    .m_axis_tdata(m_tdata[0]), .m_axis_tvalid(m_tvalid[0]), .m_axis_tready(m_tready[0]), .m_axis_tlast(m_tlast[0]),
    .overflow(ovf[0]), .busy(busy[0])
  );

  ethstream_framer #(.ADDR_BITS(4)) dut1 (
    .clk(clk), .resetn(resetn),
    .s_axis_tdata(s_tdata[1]), .s_axis_tvalid(s_tvalid[1]), .s_axis_tready(s_tready[1]), .s_axis_tlast(s_tlast[1]),
    .m_axis_tdata(m_tdata[1]), .m_axis_tvalid(m_tvalid[1]), .m_axis_tready(m_tready[1]), .m_axis_tlast(m_tlast[1]),
    .overflow(ovf[1]), .busy(busy[1])
  );

  task automatic idle();
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = 1'b0;
      s_tdata[d] = 8'h00;
      s_tlast[d] = 1'b0;
      m_tready[d] = 1'b0;
    end
  endtask

  task automatic add_packet(input int n, input bit ramp);
    for (int k = 0; k < n; k++) begin
      pkt.push_back(ramp ? 8'(k) : 8'($urandom));
      tl.push_back(k == n - 1);
    end
  endtask

  // frame model: length = min(n, depth), LSB first, then the stored bytes with tlast on the last one
  task automatic add_exp(input int d, input int start, input int n);
    int depth = d == 0 ? 2048 : 16;
    int l = n > depth ? depth : n;
    exp_d.push_back(8'(l));
    exp_d.push_back(8'(l >> 8));
    exp_l.push_back(1'b0);
    exp_l.push_back(1'b0);
    for (int k = 0; k < l; k++) begin
      exp_d.push_back(pkt[start + k]);
      exp_l.push_back(k == l - 1);
    end
  endtask

  function automatic int first_diff();
    int n = got_d.size() > exp_d.size() ? got_d.size() : exp_d.size();
    for (int k = 0; k < n; k++)
      if (k >= got_d.size() || k >= exp_d.size() || got_d[k] !== exp_d[k] || got_l[k] !== exp_l[k]) return k;
    return -1;
  endfunction

  // drives pkt into instance d and collects output beats until nfr frames end or max_beats beats are taken
  task automatic run(input int d, input int nfr, input int pct, input int max_beats);
    int i = 0, beats = 0, lasts = 0, acc_lasts = 0, cyc = 0;
    logic pv = 1'b0, pr = 1'b0, plast = 1'b0;
    logic [7:0] pdat = 8'h00;
    bit started = 0;
    got_d.delete();
    got_l.delete();
    ovf_n = 0; ovf_at = -1; stall_err = 0; hold_err = 0; span = 0; gaps = 0; timed_out = 0;
    while (lasts < nfr) begin
      s_tvalid[d] = i < pkt.size();
      s_tdata[d] = i < pkt.size() ? pkt[i] : 8'h00;
      s_tlast[d] = i < pkt.size() ? tl[i] : 1'b0;
      m_tready[d] = $urandom_range(99) < pct;
      #1;
      if (pv && !pr && (!m_tvalid[d] || m_tdata[d] !== pdat || m_tlast[d] !== plast)) stall_err++;
      if (m_tvalid[d]) started = 1;
      if (started) span++;
      if (started && !m_tvalid[d]) gaps++;
      if (acc_lasts > lasts && s_tready[d]) hold_err++;
      if (ovf[d]) begin
        ovf_n++;
        if (ovf_at < 0) ovf_at = i + 1;
      end
      if (s_tvalid[d] && s_tready[d]) begin
        if (tl[i]) acc_lasts++;
        i++;
      end
      if (m_tvalid[d] && m_tready[d]) begin
        got_d.push_back(m_tdata[d]);
        got_l.push_back(m_tlast[d]);
        beats++;
        if (m_tlast[d]) lasts++;
      end
      pv = m_tvalid[d]; pr = m_tready[d]; pdat = m_tdata[d]; plast = m_tlast[d];
      cyc++;
      if (max_beats > 0 && beats >= max_beats) break;
      if (cyc >= 5000) begin
        timed_out = 1;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (s_tready[0] !== 1'b0) begin errors++; $display("FAIL reset_s_tready got %b want 0", s_tready[0]); end
    checks++; if (m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL reset_m_tvalid got %b want 0", m_tvalid[0]); end
    checks++; if (m_tlast[0] !== 1'b0 || ovf[0] !== 1'b0 || busy[0] !== 1'b0) begin errors++; $display("FAIL reset_flags got tlast=%b ovf=%b busy=%b want 0 0 0", m_tlast[0], ovf[0], busy[0]); end
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (s_tready[0] !== 1'b1 || s_tready[1] !== 1'b1) begin errors++; $display("FAIL release_s_tready got %b%b want 11", s_tready[0], s_tready[1]); end
    checks++; if (busy[0] !== 1'b0 || m_tvalid[0] !== 1'b0) begin errors++; $display("FAIL release_idle got busy=%b valid=%b want 0 0", busy[0], m_tvalid[0]); end
    @(negedge clk);
  endtask

  task automatic test_single();
    pkt = {8'hA5}; tl = {1'b1};
    exp_d.delete(); exp_l.delete();
    add_exp(0, 0, 1);
    run(0, 1, 100, 0);
    #1;
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL single_data diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
    checks++; if (span !== 3 || gaps !== 0) begin errors++; $display("FAIL single_timing got span=%0d gaps=%0d want 3 0", span, gaps); end
    checks++; if (s_tready[0] !== 1'b1) begin errors++; $display("FAIL single_ready_after got %b want 1", s_tready[0]); end
    @(negedge clk);
  endtask

  task automatic test_long();
    pkt.delete(); tl.delete();
    add_packet(300, 1);
    exp_d.delete(); exp_l.delete();
    add_exp(0, 0, 300);
    run(0, 1, 100, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL long_data diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
    checks++; if (span !== 302 || gaps !== 0) begin errors++; $display("FAIL long_timing got span=%0d gaps=%0d want 302 0", span, gaps); end
    checks++; if (ovf_n !== 0) begin errors++; $display("FAIL long_overflow got %0d pulses want 0", ovf_n); end
  endtask

  task automatic test_stall();
    run(0, 1, 50, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL stall_data diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
    checks++; if (stall_err !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable beats want 0", stall_err); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL stall_s_tready got %0d ready cycles while draining want 0", hold_err); end
  endtask

  task automatic test_overflow();
    pkt.delete(); tl.delete();
    add_packet(20, 0);
    exp_d.delete(); exp_l.delete();
    add_exp(1, 0, 20);
    run(1, 1, 100, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL ovf20_data diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
    checks++; if (ovf_n !== 1 || ovf_at !== 17) begin errors++; $display("FAIL ovf20_pulse got count=%0d at byte %0d want 1 at 17", ovf_n, ovf_at); end
    pkt.delete(); tl.delete();
    add_packet(16, 0);
    exp_d.delete(); exp_l.delete();
    add_exp(1, 0, 16);
    run(1, 1, 100, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL ovf16_data diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
    checks++; if (ovf_n !== 0) begin errors++; $display("FAIL ovf16_pulse got %0d pulses want 0", ovf_n); end
  endtask

  task automatic test_back_to_back();
    pkt.delete(); tl.delete();
    add_packet(5, 0);
    add_packet(3, 0);
    exp_d.delete(); exp_l.delete();
    add_exp(0, 0, 5);
    add_exp(0, 5, 3);
    run(0, 2, 100, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL b2b_data diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
    checks++; if (hold_err !== 0) begin errors++; $display("FAIL b2b_hold got %0d early ready cycles want 0", hold_err); end
  endtask

  task automatic test_reset_mid();
    pkt.delete(); tl.delete();
    add_packet(10, 0);
    run(0, 1, 100, 4);
    resetn = 1'b0;
    #1;
    checks++; if (m_tvalid[0] !== 1'b0 || m_tlast[0] !== 1'b0) begin errors++; $display("FAIL rstmid_during got valid=%b tlast=%b want 0 0", m_tvalid[0], m_tlast[0]); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    checks++; if (m_tvalid[0] !== 1'b0 || m_tlast[0] !== 1'b0 || s_tready[0] !== 1'b1) begin errors++; $display("FAIL rstmid_after got valid=%b tlast=%b ready=%b want 0 0 1", m_tvalid[0], m_tlast[0], s_tready[0]); end
    @(negedge clk);
    pkt.delete(); tl.delete();
    add_packet(4, 0);
    exp_d.delete(); exp_l.delete();
    add_exp(0, 0, 4);
    run(0, 1, 100, 0);
    checks++; if (first_diff() !== -1) begin errors++; $display("FAIL rstmid_next diff at beat %0d got %0d beats want %0d", first_diff(), got_d.size(), exp_d.size()); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 24);
      pkt.delete(); tl.delete();
      add_packet(n, 0);
      exp_d.delete(); exp_l.delete();
      add_exp(1, 0, n);
      run(1, 1, $urandom_range(30, 100), 0);
      checks++; if (first_diff() !== -1 || stall_err !== 0) begin errors++; $display("FAIL rand%0d_data n=%0d diff at beat %0d stall_err=%0d want -1 0", r, n, first_diff(), stall_err); end
      checks++; if (ovf_n !== (n > 16 ? 1 : 0)) begin errors++; $display("FAIL rand%0d_overflow n=%0d got %0d pulses want %0d", r, n, ovf_n, n > 16 ? 1 : 0); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_long();
    test_stall();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
